cla_adder_pipe: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor for the RV32I datapath.

---
 rtl/cla_adder_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The block carry chain is cut into STAGES register stages, LSB group first.
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    // Handshake: an operation transfers on i_valid & o_ready; a result transfers
    // on o_valid & i_ready. The whole pipe advances together whenever the output
    // slot is empty or being drained, so o_ready is that advance enable.

    localparam int NB   = WIDTH / BLOCK;
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             cmsb;
    } grp_t;

    // First block index and block count of the group resolved by stage s.
    function automatic int grp_lo(input int s);
        return s * (NB / STAGES) + ((s < NB % STAGES) ? s : NB % STAGES);
    endfunction

    function automatic int grp_n(input int s);
        return NB / STAGES + ((s < NB % STAGES) ? 1 : 0);
    endfunction

    // Resolves blocks [lo_blk, lo_blk+n_blk); each block's internal carries are
    // flattened sum-of-products of its generate/propagate terms.
    function automatic grp_t cla_group(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] sum_in,
        input logic             cin,
        input int               lo_blk,
        input int               n_blk
    );
        grp_t             r;
        logic             c;
        logic             t;
        logic             pp;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   cc;
        r.sum  = sum_in;
        r.cout = 1'b0;
        r.cmsb = 1'b0;
        c      = cin;
        g      = '0;
        p      = '0;
        cc     = '0;
        for (int k = 0; k < NB; k++) begin
            if (k >= lo_blk && k < lo_blk + n_blk) begin
                for (int j = 0; j < BLOCK; j++) begin
                    g[j] = a[k*BLOCK+j] & b[k*BLOCK+j];
                    p[j] = a[k*BLOCK+j] ^ b[k*BLOCK+j];
                end
                cc[0] = c;
                for (int j = 0; j < BLOCK; j++) begin
                    t  = 1'b0;
                    pp = 1'b1;
                    for (int i = j; i >= 0; i--) begin
                        t  = t | (g[i] & pp);
                        pp = pp & p[i];
                    end
                    cc[j+1] = t | (pp & c);
                end
                for (int j = 0; j < BLOCK; j++) begin
                    r.sum[k*BLOCK+j] = p[j] ^ cc[j];
                end
                if (k == NB - 1) begin
                    r.cmsb = cc[BLOCK-1];
                end
                c = cc[BLOCK];
            end
        end
        r.cout = c;
        return r;
    endfunction

    logic             en;
    logic             in_v  [STAGES];
    logic [WIDTH-1:0] in_a  [STAGES];
    logic [WIDTH-1:0] in_b  [STAGES];
    logic [WIDTH-1:0] in_s  [STAGES];
    logic             in_c  [STAGES];
    grp_t             grp_d [STAGES];

    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q;
    logic             zero_q;

    assign en = ~v_q[LAST] | i_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = grp_lo(s);
        localparam int N  = grp_n(s);
        if (s == 0) begin : g_first
            // Subtraction enters as A + ~B + 1, so later stages only ever add.
            assign in_v[s] = i_valid;
            assign in_a[s] = i_a;
            assign in_b[s] = i_sub ? ~i_b : i_b;
            assign in_c[s] = i_sub | i_cin;
            assign in_s[s] = '0;
        end else begin : g_next
            assign in_v[s] = v_q[s-1];
            assign in_a[s] = a_q[s-1];
            assign in_b[s] = b_q[s-1];
            assign in_c[s] = c_q[s-1];
            assign in_s[s] = s_q[s-1];
        end
        assign grp_d[s] = cla_group(in_a[s], in_b[s], in_s[s], in_c[s], LO, N);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
                c_q[s] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= in_v[s];
                a_q[s] <= in_a[s];
                b_q[s] <= in_b[s];
                s_q[s] <= grp_d[s].sum;
                c_q[s] <= grp_d[s].cout;
            end
            ovf_q  <= grp_d[LAST].cmsb ^ grp_d[LAST].cout;
            zero_q <= (grp_d[LAST].sum == '0);
        end
    end

    assign o_ready = en;
    assign o_valid = v_q[LAST];
    assign o_sum   = s_q[LAST];
    assign o_cout  = c_q[LAST];
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule
